// File: rtl/rs_issue_sched.sv
// Reservation station with CDB wakeup and oldest-ready-first issue select.
// Holds up to DEPTH micro-ops; one insert and one issue per cycle.

package ooop_types;
  localparam int RS_PREG_W = 7;

  typedef struct packed {
    logic                 valid;
    logic [5:0]           rob_idx;
    logic [3:0]           op;
    logic [RS_PREG_W-1:0] prd;
    logic [RS_PREG_W-1:0] prs1;
    logic [RS_PREG_W-1:0] prs2;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 prs1_ready;
    logic                 prs2_ready;
  } rs_entry_t;
endpackage

module rs_issue_sched #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        ins_valid_i,
  input  ooop_types::rs_entry_t       ins_entry_i,
  output logic                        ready_o,
  input  logic                        cdb_valid_i,
  input  logic [PREG_W-1:0]           cdb_prd_i,
  output logic                        issue_valid_o,
  output ooop_types::rs_entry_t       issue_entry_o,
  input  logic                        issue_ready_i,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]      occ_q;
  ooop_types::rs_entry_t ent_q [DEPTH];
  logic [IDX_W-1:0]      age_q [DEPTH];
  logic [CNT_W-1:0]      count_q;

  logic                  ins_fire;
  logic                  issue_fire;
  logic                  wake;
  logic                  free_found;
  logic [IDX_W-1:0]      ins_idx;
  logic [DEPTH-1:0]      elig;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      sel_age;
  ooop_types::rs_entry_t ins_wr;

  // NOTE: every variable driven here gets a default before any condition,
  // otherwise a missed branch infers a latch; use blocking '=' in always_comb.
  always_comb begin
    ready_o    = (count_q < CNT_W'(DEPTH));
    ins_fire   = ins_valid_i && ready_o && !flush_i;
    wake       = cdb_valid_i && !flush_i;

    free_found = 1'b0;
    ins_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!occ_q[i] && !free_found) begin
        free_found = 1'b1;
        ins_idx    = IDX_W'(i);
      end
    end

    // Eligibility looks only at registered state, so a slot written this
    // cycle cannot be chosen until the following one.
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = occ_q[i]
             && (!ent_q[i].rs1_used || ent_q[i].prs1_ready)
             && (!ent_q[i].rs2_used || ent_q[i].prs2_ready);
    end

    // Strict '>' keeps the lowest index on an age tie.
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end

    issue_valid_o = sel_found && !flush_i;
    issue_entry_o = issue_valid_o ? ent_q[sel_idx] : '0;
    issue_fire    = issue_valid_o && issue_ready_i;
    count_o       = count_q;

    ins_wr       = ins_entry_i;
    ins_wr.valid = 1'b1;
    if (wake && ins_entry_i.rs1_used && ins_entry_i.prs1 == cdb_prd_i)
      ins_wr.prs1_ready = 1'b1;
    if (wake && ins_entry_i.rs2_used && ins_entry_i.prs2 == cdb_prd_i)
      ins_wr.prs2_ready = 1'b1;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (flush_i) begin
      occ_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ins_fire && ins_idx == IDX_W'(i)) begin
          occ_q[i] <= 1'b1;
          age_q[i] <= '0;
        end else if (ins_fire && occ_q[i] && age_q[i] != IDX_W'(DEPTH - 1)) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
      // The inserted slot was free, so it never collides with the issued one.
      if (issue_fire) occ_q[sel_idx] <= 1'b0;
      count_q <= count_q + CNT_W'(ins_fire) - CNT_W'(issue_fire);
    end
  end

  // NOTE: the payload array has no reset; occ_q gates every use of it, and
  // leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_fire && ins_idx == IDX_W'(i)) begin
        ent_q[i] <= ins_wr;
      end else if (wake && occ_q[i]) begin
        if (ent_q[i].rs1_used && ent_q[i].prs1 == cdb_prd_i) ent_q[i].prs1_ready <= 1'b1;
        if (ent_q[i].rs2_used && ent_q[i].prs2 == cdb_prd_i) ent_q[i].prs2_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed, table-driven bench for rs_issue_sched (DEPTH=8, PREG_W=7).
// Inputs change on the falling edge; outputs are compared 1 ns later.

module tb_rs_issue_sched;
  import ooop_types::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            ins_valid_i;
  rs_entry_t       ins_entry_i;
  logic            ready_o;
  logic            cdb_valid_i;
  logic [6:0]      cdb_prd_i;
  logic            issue_valid_o;
  rs_entry_t       issue_entry_o;
  logic            issue_ready_i;
  logic [3:0]      count_o;

  int checks = 0;
  int errors = 0;

  rs_issue_sched #(.DEPTH(8), .PREG_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .ins_valid_i   (ins_valid_i),
    .ins_entry_i   (ins_entry_i),
    .ready_o       (ready_o),
    .cdb_valid_i   (cdb_valid_i),
    .cdb_prd_i     (cdb_prd_i),
    .issue_valid_o (issue_valid_o),
    .issue_entry_o (issue_entry_o),
    .issue_ready_i (issue_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       flush;
    logic       ins_v;
    rs_entry_t  ent;
    logic       cdb_v;
    logic [6:0] cdb;
    logic       iss_rdy;
    logic       e_ready;
    logic       e_iv;
    logic [6:0] e_prd;
    logic [1:0] e_rb;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sources that are used start not-ready; unused sources leave ready bits 0.
  function automatic rs_entry_t mk(input logic [6:0] prd, input logic u1, input logic [6:0] p1,
                                   input logic u2, input logic [6:0] p2);
    rs_entry_t e;
    e          = '0;
    e.prd      = prd;
    e.rs1_used = u1;
    e.prs1     = p1;
    e.rs2_used = u2;
    e.prs2     = p2;
    return e;
  endfunction

  function automatic vec_t v(input string nm, input logic fl, input logic iv_in, input rs_entry_t e,
                             input logic cv, input logic [6:0] cp, input logic ir,
                             input logic er, input logic eiv, input logic [6:0] eprd,
                             input logic [1:0] erb, input logic [3:0] ecnt);
    vec_t r;
    r.name = nm;  r.flush = fl;  r.ins_v = iv_in;  r.ent = e;
    r.cdb_v = cv; r.cdb = cp;    r.iss_rdy = ir;
    r.e_ready = er; r.e_iv = eiv; r.e_prd = eprd; r.e_rb = erb; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic drive_idle();
    flush_i       = 1'b0;
    ins_valid_i   = 1'b0;
    ins_entry_i   = '0;
    cdb_valid_i   = 1'b0;
    cdb_prd_i     = '0;
    issue_ready_i = 1'b0;
  endtask

  task automatic check_outputs(input string nm, input logic er, input logic eiv,
                               input logic [6:0] eprd, input logic [1:0] erb, input logic [3:0] ecnt);
    check({nm, ".ready"},  64'(ready_o),             64'(er));
    check({nm, ".ivalid"}, 64'(issue_valid_o),       64'(eiv));
    check({nm, ".evalid"}, 64'(issue_entry_o.valid), 64'(eiv));
    check({nm, ".prd"},    64'(issue_entry_o.prd),   64'(eprd));
    check({nm, ".rdybits"}, 64'({issue_entry_o.prs1_ready, issue_entry_o.prs2_ready}), 64'(erb));
    check({nm, ".count"},  64'(count_o),             64'(ecnt));
  endtask

  initial begin
    rs_entry_t none;
    none = '0;

    // Fill: 8 always-ready entries, then a rejected 9th, then drain two.
    tbl.push_back(v("idle0",  0,0,none,0,0,0, 1,0,0,0,0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(v($sformatf("fill%0d", k), 0,1,mk(7'(10+k),0,0,0,0),0,0,0,
                      1, k > 0, (k > 0) ? 7'd10 : 7'd0, 2'b00, 4'(k)));
    tbl.push_back(v("full_ins", 0,1,mk(18,0,0,0,0),0,0,0, 0,1,10,0,8));
    tbl.push_back(v("iss_old0", 0,0,none,0,0,1,         0,1,10,0,8));
    tbl.push_back(v("iss_old1", 0,0,none,0,0,1,         1,1,11,0,7));
    // Flush with a pending insert and a willing FU.
    tbl.push_back(v("flush6",   1,1,mk(18,0,0,0,0),0,0,1, 1,0,0,0,6));
    tbl.push_back(v("post_fl",  0,0,none,0,0,0,         1,0,0,0,0));
    // A waits on p5, B ready: B goes first, A after the broadcast.
    tbl.push_back(v("ins_A",    0,1,mk(20,1,5,0,0),0,0,0, 1,0,0,0,0));
    tbl.push_back(v("ins_B",    0,1,mk(21,0,0,0,0),0,0,0, 1,0,0,0,1));
    tbl.push_back(v("offer_B",  0,0,none,0,0,0,         1,1,21,0,2));
    tbl.push_back(v("iss_B",    0,0,none,0,0,1,         1,1,21,0,2));
    tbl.push_back(v("cdb5",     0,0,none,1,5,0,         1,0,0,0,1));
    tbl.push_back(v("offer_A",  0,0,none,0,0,0,         1,1,20,2'b10,1));
    tbl.push_back(v("iss_A",    0,0,none,0,0,1,         1,1,20,2'b10,1));
    // C inserted while its prs2 is broadcast.
    tbl.push_back(v("ins_C",    0,1,mk(22,0,0,1,9),1,9,0, 1,0,0,0,0));
    tbl.push_back(v("iss_C",    0,0,none,0,0,1,         1,1,22,2'b01,1));
    tbl.push_back(v("empty",    0,0,none,0,0,0,         1,0,0,0,0));
    // Four entries, then insert and issue together.
    for (int k = 0; k < 4; k++)
      tbl.push_back(v($sformatf("ins_D%0d", k), 0,1,mk(7'(30+k),0,0,0,0),0,0,0,
                      1, k > 0, (k > 0) ? 7'd30 : 7'd0, 2'b00, 4'(k)));
    tbl.push_back(v("ins_iss",  0,1,mk(34,0,0,0,0),0,0,1, 1,1,30,0,4));
    tbl.push_back(v("after_ii", 0,0,none,0,0,0,         1,1,31,0,4));
    tbl.push_back(v("reuse0",   0,1,mk(35,0,0,0,0),0,0,0, 1,1,31,0,4));
    tbl.push_back(v("young0",   0,0,none,0,0,0,         1,1,31,0,5));
    tbl.push_back(v("flush5",   1,0,none,0,0,0,         1,0,0,0,5));
    tbl.push_back(v("post_fl2", 0,0,none,0,0,0,         1,0,0,0,0));
    // Older F wakes up and overtakes the already offered younger G.
    tbl.push_back(v("ins_F",    0,1,mk(50,1,40,0,0),0,0,0, 1,0,0,0,0));
    tbl.push_back(v("ins_G",    0,1,mk(51,0,0,0,0),0,0,0, 1,0,0,0,1));
    tbl.push_back(v("cdb40",    0,0,none,1,40,0,        1,1,51,0,2));
    tbl.push_back(v("offer_F",  0,0,none,0,0,0,         1,1,50,2'b10,2));

    rst_n = 1'b0;
    drive_idle();
    #1;
    check_outputs("reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      flush_i       = tbl[i].flush;
      ins_valid_i   = tbl[i].ins_v;
      ins_entry_i   = tbl[i].ent;
      cdb_valid_i   = tbl[i].cdb_v;
      cdb_prd_i     = tbl[i].cdb;
      issue_ready_i = tbl[i].iss_rdy;
      #1;
      check_outputs(tbl[i].name, tbl[i].e_ready, tbl[i].e_iv, tbl[i].e_prd, tbl[i].e_rb, tbl[i].e_cnt);
    end

    // Third entry, then asynchronous reset between edges.
    @(negedge clk);
    drive_idle();
    ins_valid_i = 1'b1;
    ins_entry_i = mk(52,0,0,0,0);
    @(negedge clk);
    drive_idle();
    #1;
    check("hold3.count", 64'(count_o), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1, 0, 0, 0, 0);
    check("async_rst.entry", 64'(issue_entry_o), 64'd0);
    @(negedge clk);
    issue_ready_i = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 Parameter DEPTH, default 8, number of reservation-station entries; power of two, minimum 2.
REQ-002 Parameter PREG_W, default 7, physical-register tag width; equals the width of rs_entry_t.prs1/prs2/prd.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush_i  input  1  pipeline flush; discards all entries.
REQ-006 ins_valid_i  input  1  insert request from dispatch.
REQ-007 ins_entry_i  input  ooop_types::rs_entry_t  entry to insert.
REQ-008 ready_o  output  1  space available; to dispatch rs_*_ready_i.
REQ-009 cdb_valid_i  input  1  a result broadcast is present.
REQ-010 cdb_prd_i  input  PREG_W  physical tag being broadcast.
REQ-011 issue_valid_o  output  1  an entry is offered to the functional unit.
REQ-012 issue_entry_o  output  ooop_types::rs_entry_t  offered entry, with valid=1 and current ready bits.
REQ-013 issue_ready_i  input  1  the functional unit accepts the offered entry.
REQ-014 count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Storage: DEPTH slots, each holding an occupied bit, an rs_entry_t, and an age value of $clog2(DEPTH) bits.
REQ-016 ready_o SHALL be 1 iff count_o < DEPTH.
- ready_o derives from registered state only.
- A free in the current cycle does not raise ready_o until the next cycle.
REQ-017 Insert fires when ins_valid_i && ready_o && !flush_i.
- The entry is written to the lowest-index free slot.
- The slot's age is set to 0.
- The age of every other occupied slot increments by 1, saturating at DEPTH-1.
REQ-018 Source readiness: src1_ok = !rs1_used || prs1_ready; src2_ok = !rs2_used || prs2_ready.
- A slot is eligible iff it is occupied, src1_ok && src2_ok, and it was not inserted this cycle.
REQ-019 Wakeup applies when cdb_valid_i is high.
- Any occupied slot with rs1_used && prs1 == cdb_prd_i sets prs1_ready.
- Any occupied slot with rs2_used && prs2 == cdb_prd_i sets prs2_ready.
- Takes effect at the next edge; issue eligibility follows one cycle after the broadcast.
REQ-020 Same-cycle insert+wakeup: if ins_entry_i's prs1/prs2 matches cdb_prd_i while cdb_valid_i is high, the stored ready bit is set on write.
REQ-021 Select: issue_valid_o = 1 iff some slot is eligible and flush_i == 0.
- The chosen slot is the eligible one with the largest age.
- Ties are broken by the lowest index.
- issue_entry_o is the chosen slot's contents; '0 when issue_valid_o == 0.
REQ-022 Issue fires when issue_valid_o && issue_ready_i; the chosen slot is freed at the edge.
- If no issue fires, the selection holds until accepted or until an older entry becomes eligible.
- issue_valid_o does not depend combinationally on issue_ready_i.
REQ-023 Simultaneous insert and issue in one cycle are both honoured; count_o is unchanged.
REQ-024 Wakeup is disabled while flush_i is high.
- Flush clears all occupied bits at the edge; count_o becomes 0.
- An insert in the flush cycle is dropped.
- An issue in the flush cycle is suppressed (issue_valid_o is forced to 0).
REQ-025 count_o next-state = count + insert_fire - issue_fire.
- It never exceeds DEPTH and never underflows.

Reset
REQ-026 While rst_n is 0, all state clears asynchronously:
- all occupied bits = 0, ages = 0, count_o = 0;
- ready_o = 1, issue_valid_o = 0, issue_entry_o = '0.
REQ-027 Reset mid-operation discards all entries; no issue fires on the first edge after rst_n rises.

Verification
REQ-028 Insert 8 entries with all sources ready and issue_ready_i=0 → count_o=8, ready_o=0.
- A 9th ins_valid_i is not accepted.
- Setting issue_ready_i=1 issues slot 0 (the oldest) first.
REQ-029 Insert A (prs1=5, not ready), then B (ready) → B issues first.
- cdb_valid_i=1, cdb_prd_i=5 in cycle N → A is offered in cycle N+1.
REQ-030 Insert C with prs2=9 not ready while the CDB broadcasts 9 in the same cycle → C is offered the following cycle.
REQ-031 With count_o=4, drive insert and an accepted issue in the same cycle → count_o stays 4, and the issued entry is the oldest eligible one.
REQ-032 With count_o=6 and ins_valid_i=1, assert flush_i for 1 cycle → issue_valid_o=0 in that cycle, then count_o=0 and ready_o=1.
REQ-033 Drop rst_n asynchronously between edges with 3 entries held → outputs reach their reset values before the next edge; no issue follows.
